// File: rtl/data_memory_be.sv
// data_memory_be: single-port word memory with byte-lane writes and optional zero-fill after reset
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req, we           access request and write select (1 = write, 0 = read)
//   be, addr, d_in    byte-lane enables, word address, write data
//   ready             high when requests are accepted (RUN state)
//   d_out, valid      registered read data and its one-cycle qualifier
//   err               one-cycle pulse for an accepted access with addr >= VOLUME
module data_memory_be #(
  parameter int WIDTH = 32,
  parameter int VOLUME = 64,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH = (VOLUME > 1) ? $clog2(VOLUME) : 1,
  localparam int LANES = WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [LANES-1:0]      be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      d_in,
  output logic                  ready,
  output logic [WIDTH-1:0]      d_out,
  output logic                  valid,
  output logic                  err
);
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_WIDTH:0] VOL = VOLUME[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(VOLUME - 1);
  state_t state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [WIDTH-1:0] mem [VOLUME];
  logic acc, in_range, clr_we;
  assign in_range = {1'b0, addr} < VOL;
  assign acc = req & ready;
  // Reset always lands in CLEAR so ready is low under reset; without fill, CLEAR lasts one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CLEAR;
    else state <= state_nx;
  end
  always_comb state_nx = (state == RUN || CLEAR_ON_RESET == 0 || clr_cnt == LAST) ? RUN : CLEAR;
  always_comb begin
    ready = state == RUN;
    clr_we = state == CLEAR && CLEAR_ON_RESET != 0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clr_cnt <= '0;
    else if (clr_we) clr_cnt <= (clr_cnt == LAST) ? '0 : clr_cnt + 1'b1;
  end
  // Array has no reset; the fill is gated by rst_n so a held reset never touches contents.
  always_ff @(posedge clk) begin
    if (rst_n && clr_we) mem[clr_cnt] <= '0;
    else if (acc && we && in_range)
      for (int i = 0; i < LANES; i++)
        if (be[i]) mem[addr][8*i +: 8] <= d_in[8*i +: 8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= '0;
      valid <= 1'b0;
      err <= 1'b0;
    end else begin
      valid <= acc & ~we;
      err <= acc & ~in_range;
      if (acc && !we) d_out <= in_range ? mem[addr] : '0;
    end
  end
endmodule

// File: tb/tb_data_memory_be.sv
// tb_data_memory_be: randomized self-checking bench with a word-array reference model
module tb_data_memory_be;
  localparam int V = 48;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, req, we, ready, valid, err;
  logic [3:0] be;
  logic [5:0] addr;
  logic [31:0] d_in, d_out;
  logic nc_rst_n, nc_req, nc_we, nc_ready, nc_valid, nc_err;
  logic [3:0] nc_be;
  logic [5:0] nc_addr;
  logic [31:0] nc_din, nc_dout;
  int errors = 0;
  int checks = 0;
  logic [31:0] model [V];
  logic [31:0] exp_dout;

  data_memory_be #(.WIDTH(32), .VOLUME(V), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .d_in(d_in),
    .ready(ready), .d_out(d_out), .valid(valid), .err(err));

  data_memory_be #(.WIDTH(32), .VOLUME(V), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst_n(nc_rst_n), .req(nc_req), .we(nc_we), .be(nc_be), .addr(nc_addr), .d_in(nc_din),
    .ready(nc_ready), .d_out(nc_dout), .valid(nc_valid), .err(nc_err));

  task automatic check_zero(input string nm);
    checks++;
    if ({ready, valid, err, d_out} !== 35'd0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b err=%b d_out=%h, want all zero", nm, ready, valid, err, d_out);
    end
  endtask

  // One accepted-or-idle cycle in RUN; expectations come from the word-array model.
  task automatic drive(input logic r, input logic w, input logic [3:0] b, input logic [5:0] a,
                       input logic [31:0] d, input string nm);
    logic ev, ee;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL %s ready: got %b want 1", nm, ready); end
    req = r; we = w; be = b; addr = a; d_in = d;
    @(posedge clk); #1;
    req = 1'b0;
    if (r && w && a < V)
      for (int i = 0; i < 4; i++) if (b[i]) model[a][8*i +: 8] = d[8*i +: 8];
    if (r && !w) exp_dout = (a < V) ? model[a] : 32'h0;
    ev = r && !w;
    ee = r && a >= V;
    checks++;
    if (valid !== ev) begin errors++; $display("FAIL %s valid: got %b want %b", nm, valid, ev); end
    checks++;
    if (err !== ee) begin errors++; $display("FAIL %s err: got %b want %b", nm, err, ee); end
    checks++;
    if (d_out !== exp_dout) begin errors++; $display("FAIL %s d_out: got %h want %h", nm, d_out, exp_dout); end
  endtask

  // Release reset at posedge+1 and count edges until ready; requests during fill must be ignored.
  task automatic release_and_clear(input string nm);
    int n;
    n = 0;
    rst_n = 1'b1;
    req = 1'b1; we = 1'b1; be = 4'hf; addr = 6'd5; d_in = 32'hFFFF_FFFF;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      n++;
      checks++;
      if (valid !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse during fill: valid=%b err=%b want 0", nm, valid, err);
      end
      if (ready === 1'b1) break;
    end
    req = 1'b0;
    checks++;
    if (n != V) begin errors++; $display("FAIL %s fill length: got %0d want %0d", nm, n, V); end
    for (int i = 0; i < V; i++) model[i] = 32'h0;
  endtask

  task automatic test_reset();
    req = 1'b1; we = 1'b0; be = 4'h0; addr = 6'd0; d_in = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_zero("reset_hold");
    end
    req = 1'b0;
    exp_dout = 32'h0;
  endtask

  task automatic test_clear();
    release_and_clear("clear");
    drive(1'b1, 1'b0, 4'h0, 6'd47, 32'h0, "rd47");
    drive(1'b1, 1'b0, 4'h0, 6'd5, 32'h0, "rd5_ignored_wr");
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 1'b1, 4'hf, 6'd5, 32'hDEADBEEF, "wr_full");
    drive(1'b1, 1'b1, 4'h1, 6'd5, 32'h000000AA, "wr_lane0");
    drive(1'b1, 1'b0, 4'h0, 6'd5, 32'h0, "rd_merged");
    checks++;
    if (d_out !== 32'hDEADBEAA) begin errors++; $display("FAIL merged_const: got %h want deadbeaa", d_out); end
    drive(1'b0, 1'b0, 4'h0, 6'd0, 32'h0, "idle_hold");
    drive(1'b1, 1'b1, 4'h0, 6'd5, 32'h12345678, "wr_be0");
    drive(1'b1, 1'b0, 4'h0, 6'd5, 32'h0, "rd_after_be0");
    drive(1'b1, 1'b1, 4'h6, 6'd5, 32'h11223344, "wr_mid_lanes");
    drive(1'b1, 1'b0, 4'h0, 6'd5, 32'h0, "rd_mid_lanes");
  endtask

  task automatic test_out_of_range();
    drive(1'b1, 1'b0, 4'h0, 6'd50, 32'h0, "rd50");
    drive(1'b1, 1'b1, 4'hf, 6'd50, 32'h1, "wr50");
    drive(1'b1, 1'b0, 4'h0, 6'd2, 32'h0, "rd2");
    checks++;
    if (d_out !== 32'h0) begin errors++; $display("FAIL rd2_const: got %h want 0", d_out); end
    drive(1'b1, 1'b0, 4'h0, 6'd63, 32'h0, "rd63");
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 3; i++) drive(1'b1, 1'b1, 4'hf, 6'(i), 32'(i), "b2b_wr");
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 4'h0, 6'(i), 32'h0, "b2b_rd");
      checks++;
      if (d_out !== 32'(i)) begin errors++; $display("FAIL b2b_const: got %h want %h", d_out, 32'(i)); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 4'($urandom), 6'($urandom_range(0, 63)),
            $urandom, "random");
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 4'hf, 6'd7, 32'h5A5A5A5A, "w7");
    req = 1'b1; we = 1'b0; addr = 6'd7;
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b1 || d_out !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL pre_reset_read: valid=%b d_out=%h want 1/5a5a5a5a", valid, d_out);
    end
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      check_zero("reset_with_req");
    end
    req = 1'b0;
    exp_dout = 32'h0;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid_fill");
    @(posedge clk); #1;
    release_and_clear("restart");
    drive(1'b1, 1'b0, 4'h0, 6'd7, 32'h0, "rd7_after_refill");
    drive(1'b1, 1'b0, 4'h0, 6'd30, 32'h0, "rd30_after_refill");
  endtask

  task automatic test_no_clear();
    checks++;
    if ({nc_ready, nc_valid, nc_err} !== 3'b000) begin
      errors++;
      $display("FAIL nc_reset: ready=%b valid=%b err=%b want 0", nc_ready, nc_valid, nc_err);
    end
    nc_rst_n = 1'b1;
    @(posedge clk); #1;
    nc_req = 1'b0;
    checks++;
    if ({nc_ready, nc_valid, nc_err} !== 3'b100) begin
      errors++;
      $display("FAIL nc_first_edge: ready=%b valid=%b err=%b want 1/0/0", nc_ready, nc_valid, nc_err);
    end
    nc_req = 1'b1; nc_we = 1'b1; nc_be = 4'hf; nc_addr = 6'd3; nc_din = 32'hCAFEF00D;
    @(posedge clk); #1;
    nc_we = 1'b0;
    @(posedge clk); #1;
    nc_req = 1'b0;
    checks++;
    if (nc_valid !== 1'b1 || nc_err !== 1'b0 || nc_dout !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL nc_readback: valid=%b err=%b d_out=%h want 1/0/cafef00d", nc_valid, nc_err, nc_dout);
    end
  endtask

  initial begin
    rst_n = 1'b1; nc_rst_n = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 6'd0; d_in = 32'h0;
    nc_req = 1'b1; nc_we = 1'b0; nc_be = 4'h0; nc_addr = 6'd3; nc_din = 32'h0;
    exp_dout = 32'h0;
    #1;
    rst_n = 1'b0; nc_rst_n = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_clear();
    test_byte_enable();
    test_out_of_range();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_no_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
